// File: rtl/bg_scroll_pkg.sv
// bg_scroll_pkg -- shared definitions for the scrolling road background.
//   Colour constants (3-bit RGB), default screen/road geometry and the
//   redraw FSM state type. Imported by bg_pattern and bg_scroll_ctrl.
package bg_scroll_pkg;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] WHITE  = 3'b111;

    localparam int DEF_H_RES  = 160;
    localparam int DEF_V_RES  = 120;
    localparam int DEF_ROAD_L = 40;
    localparam int DEF_ROAD_R = 119;
    localparam int DEF_LANE_X = 79;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bg_pattern.sv
// bg_pattern -- combinational colour lookup for one background pixel.
//   Inputs : x (8b column), y (7b row), offset (4b scroll phase)
//   Output : colour (3b RGB)
//   Grass outside the road, white road edges, a 2-wide dashed yellow centre
//   line (8 rows on, 8 off, shifted down by offset), black tarmac elsewhere.
//   Build option: BG_BORDER_EN paints the outermost screen ring white,
//   overriding everything else.
module bg_pattern
    import bg_scroll_pkg::*;
#(
`ifdef BG_BORDER_EN
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
`endif
    parameter int ROAD_L = DEF_ROAD_L,
    parameter int ROAD_R = DEF_ROAD_R,
    parameter int LANE_X = DEF_LANE_X
)(
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [3:0] offset,
    output logic [2:0] colour
);

    localparam logic [7:0] RL  = 8'(ROAD_L);
    localparam logic [7:0] RR  = 8'(ROAD_R);
    localparam logic [7:0] LX0 = 8'(LANE_X);
    localparam logic [7:0] LX1 = 8'(LANE_X + 1);
`ifdef BG_BORDER_EN
    localparam logic [7:0] XL  = 8'(H_RES - 1);
    localparam logic [6:0] YL  = 7'(V_RES - 1);
`endif

    // (y - offset) mod 16 < 8 is just bit 3 of the difference being clear.
    logic dash_on;
    assign dash_on = ((y - {3'b000, offset}) & 7'd8) == 7'd0;

    always_comb begin
        colour = BLACK;
        if (x < RL || x > RR)
            colour = GREEN;
        else if (x == RL || x == RR)
            colour = WHITE;
        else if ((x == LX0 || x == LX1) && dash_on)
            colour = YELLOW;
`ifdef BG_BORDER_EN
        if (x == 8'd0 || x == XL || y == 7'd0 || y == YL)
            colour = WHITE;
`endif
    end

endmodule

// File: rtl/bg_scroll_ctrl.sv
// bg_scroll_ctrl -- per-frame redraw of a scrolling road background.
//   Clock, Resetn (synchronous, active-low)
//   frame_tick/enable : start a redraw; speed (3b) rows scrolled per frame
//   x, y, colour, plot: registered pixel stream to the VGA adapter
//   busy              : redraw in progress (DRAW or DONE)
//   frame_done        : one-cycle pulse after the last pixel
//   offset            : current 4-bit scroll phase
//   overrun           : sticky, set when a tick arrives while busy
//   Build option: BG_BORDER_EN (white screen border, see bg_pattern).
module bg_scroll_ctrl
    import bg_scroll_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ROAD_L = DEF_ROAD_L,
    parameter int ROAD_R = DEF_ROAD_R,
    parameter int LANE_X = DEF_LANE_X
)(
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic [2:0] speed,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       frame_done,
    output logic [3:0] offset,
    output logic       overrun
);

    localparam logic [7:0] X_LAST = 8'(H_RES - 1);
    localparam logic [6:0] Y_LAST = 7'(V_RES - 1);

    state_t     state, state_nxt;
    logic [7:0] x_nxt;
    logic [6:0] y_nxt;
    logic [3:0] offset_nxt;
    logic       plot_nxt;
    logic [2:0] pat_colour;

    // The pattern sees the *next* coordinates/offset so colour lands in the
    // same register stage as x, y and plot.
    bg_pattern #(
`ifdef BG_BORDER_EN
        .H_RES  (H_RES),
        .V_RES  (V_RES),
`endif
        .ROAD_L (ROAD_L),
        .ROAD_R (ROAD_R),
        .LANE_X (LANE_X)
    ) u_pattern (
        .x      (x_nxt),
        .y      (y_nxt),
        .offset (offset_nxt),
        .colour (pat_colour)
    );

    always_comb begin
        state_nxt  = state;
        x_nxt      = x;
        y_nxt      = y;
        offset_nxt = offset;
        plot_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick && enable) begin
                    // speed only matters here; later changes are never seen.
                    offset_nxt = offset + {1'b0, speed};
                    x_nxt      = 8'd0;
                    y_nxt      = 7'd0;
                    plot_nxt   = 1'b1;
                    state_nxt  = DRAW;
                end
            end
            DRAW: begin
                if (x == X_LAST && y == Y_LAST) begin
                    state_nxt = DONE;
                end else begin
                    plot_nxt = 1'b1;
                    if (x == X_LAST) begin
                        x_nxt = 8'd0;
                        y_nxt = y + 7'd1;
                    end else begin
                        x_nxt = x + 8'd1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state   <= IDLE;
            x       <= 8'd0;
            y       <= 7'd0;
            colour  <= BLACK;
            plot    <= 1'b0;
            offset  <= 4'd0;
            overrun <= 1'b0;
        end else begin
            state  <= state_nxt;
            x      <= x_nxt;
            y      <= y_nxt;
            offset <= offset_nxt;
            plot   <= plot_nxt;
            if (plot_nxt)
                colour <= pat_colour;
            // enable plays no part here: any tick while busy is lost.
            if (frame_tick && state != IDLE)
                overrun <= 1'b1;
        end
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// tb_bg_scroll_ctrl -- self-checking bench for bg_scroll_ctrl.
//   Each accepted tick pushes the full expected pixel stream of the frame
//   into a queue; every plot cycle pops and compares {x,y,colour}.
module tb_bg_scroll_ctrl;

    localparam int HR   = 160;
    localparam int VR   = 120;
    localparam int NPIX = HR * VR;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] speed = 3'd0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, frame_done, overrun;
    logic [3:0] offset;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_off = 4'd0;
    logic [17:0] exp_q[$];
    logic [2:0] obs [HR][VR];

    always #10 Clock = ~Clock;

    bg_scroll_ctrl dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .frame_tick (frame_tick),
        .enable     (enable),
        .speed      (speed),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .frame_done (frame_done),
        .offset     (offset),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_colour(input int px, input int py, input int off);
`ifdef BG_BORDER_EN
        if (px == 0 || px == HR-1 || py == 0 || py == VR-1) return 3'b111;
`endif
        if (px < 40 || px > 119)   return 3'b010;
        if (px == 40 || px == 119) return 3'b111;
        if ((px == 79 || px == 80) && ((((py - off) % 16) + 16) % 16) < 8) return 3'b110;
        return 3'b000;
    endfunction

    task automatic do_reset();
        @(negedge Clock);
        Resetn = 1'b0; frame_tick = 1'b0;
        repeat (2) @(negedge Clock);
        chk("rst_overrun", overrun, 0);
        chk("rst_offset", offset, 0);
        Resetn = 1'b1;
        exp_off = 4'd0;
        exp_q.delete();
    endtask

    // One tick; drop_at>0 injects a tick in DRAW, stop_at>0 resets mid-frame.
    task automatic do_frame(input logic [2:0] spd, input int drop_at, input int stop_at);
        int plots = 0;
        bit done = 1'b0;
        @(negedge Clock);
        speed = spd; enable = 1'b1; frame_tick = 1'b1;
        exp_off = exp_off + 4'(spd);
        for (int j = 0; j < VR; j++)
            for (int i = 0; i < HR; i++)
                exp_q.push_back({8'(i), 7'(j), ref_colour(i, j, int'(exp_off))});
        for (int k = 1; k <= NPIX + 4 && !done; k++) begin
            @(negedge Clock);
            if (plot) begin
                plots++;
                if (x < HR && y < VR) obs[x][y] = colour;
                if (exp_q.size() == 0) chk("extra_pixel", plots, NPIX);
                else chk("pixel", {x, y, colour}, exp_q.pop_front());
            end
            if (frame_done) begin
                chk("done_cycle", k, NPIX + 1);
                chk("done_busy", busy, 1);
                done = 1'b1;
            end
            // Mid-frame input churn that must not disturb the frame.
            frame_tick = (k == drop_at);
            speed      = 3'(k);
            enable     = !(k >= 100 && k < 400);
            if (k == stop_at) begin
                chk("abort_pos", {x, y}, {8'((k-1) % HR), 7'((k-1) / HR)});
                chk("abort_pre_off", offset, exp_off);
                Resetn = 1'b0; frame_tick = 1'b0;
                @(negedge Clock);
                chk("abort_plot", plot, 0);
                chk("abort_offset", offset, 0);
                chk("abort_busy", busy, 0);
                chk("abort_overrun", overrun, 0);
                Resetn = 1'b1; speed = spd; enable = 1'b1;
                exp_q.delete();
                exp_off = 4'd0;
                return;
            end
        end
        frame_tick = 1'b0; speed = spd; enable = 1'b1;
        chk("frame_done_seen", done, 1);
        chk("plot_count", plots, NPIX);
        chk("q_left", exp_q.size(), 0);
        chk("offset", offset, exp_off);
        @(negedge Clock);
        chk("idle_busy", busy, 0);
        chk("idle_plot", plot, 0);
    endtask

    initial begin
        logic [2:0] corner;
`ifdef BG_BORDER_EN
        corner = 3'b111;
`else
        corner = 3'b010;
`endif
        // Reset held for two edges: every output cleared.
        Resetn = 1'b0;
        repeat (2) @(negedge Clock);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_offset", offset, 0);
        chk("rst_overrun", overrun, 0);
        Resetn = 1'b1;

        // Full frame at speed 3: stripes, corners, timing.
        do_frame(3'd3, 0, 0);
        chk("off_3", offset, 4'd3);
        chk("px_0_0", obs[0][0], corner);
        chk("px_159_119", obs[159][119], corner);
        chk("px_79_3", obs[79][3], 3'b110);
        chk("px_80_10", obs[80][10], 3'b110);
        chk("px_79_2", obs[79][2], 3'b000);
`ifdef BG_BORDER_EN
        chk("px_79_0", obs[79][0], 3'b111);
`endif
        chk("ovr_clean", overrun, 0);

        // Tick with enable low in IDLE: ignored, no overrun.
        @(negedge Clock); enable = 1'b0; frame_tick = 1'b1;
        @(negedge Clock); frame_tick = 1'b0; enable = 1'b1;
        chk("dis_busy", busy, 0);
        chk("dis_plot", plot, 0);
        @(negedge Clock);
        chk("dis_overrun", overrun, 0);
        chk("dis_offset", offset, 4'd3);

        // Speed 7 from zero wraps 7, 14, 5; first frame drops a tick.
        do_reset();
        do_frame(3'd7, 500, 0);
        chk("off_7", offset, 4'd7);
        chk("ovr_set", overrun, 1);
        do_frame(3'd7, 0, 0);
        chk("off_14", offset, 4'd14);
        chk("ovr_sticky", overrun, 1);
        do_frame(3'd7, 0, 0);
        chk("off_5", offset, 4'd5);

        // Speed 0 frame aborted by reset at pixel (20,60), then restart.
        do_frame(3'd0, 0, 60 * HR + 20 + 1);
        do_frame(3'd1, 0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
